// File: rtl/lowres_op_arbiter.sv
// lowres_op_arbiter: hands a single opcode core to one of two requesters for a whole job.
// Optional watchdog abort is compiled in when LOWRES_ARB_TIMEOUT_EN is defined.
module lowres_op_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0][3:0] r_op,
  input  logic [1:0]      r_valid,
  input  logic [1:0]      r_last,
  output logic [1:0]      r_ready,
  output logic [1:0]      grant,
  output logic [1:0]      done,
  output logic            error,
  output logic [3:0]      op_in,
  output logic            op_valid_in,
  input  logic            ready_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       owner_q, owner_d;
  logic       prio_q, prio_d;
  logic       last_q, last_d;

  logic       accept;
  logic       finish;
  logic       timeout_hit;
  logic       winner;
  logic       fire;
  logic [1:0] owner_oh;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign owner_oh = {owner_q, ~owner_q};
  // Contention is settled by the priority pointer; a lone request always wins.
  assign winner   = (req == 2'b11) ? prio_q : req[1];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    last_d  = last_q;
    accept  = 1'b0;
    finish  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          owner_d = winner;
          grant_d = winner ? 2'b10 : 2'b01;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_valid[owner_q] && ready_out) begin
          accept  = 1'b1;
          last_d  = r_last[owner_q];
          state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        // The core needs a cycle to drop ready_out after a strobe, so it is ignored here.
        state_d = last_q ? ST_DRAIN : ST_ISSUE;
      end
      ST_DRAIN: begin
        if (ready_out) begin
          finish = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish || timeout_hit) begin
      grant_d = 2'b00;
      prio_d  = ~owner_q;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      last_q  <= last_d;
    end
  end

`ifdef LOWRES_ARB_TIMEOUT_EN
  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            stall;
  logic            enter_wait;

  assign stall       = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) && !ready_out;
  assign enter_wait  = (state_d != state_q) && ((state_d == ST_ISSUE) || (state_d == ST_DRAIN));
  // The cycle that would bring the count to TIMEOUT_CYCLES is the abort cycle.
  assign timeout_hit = stall && (wd_q == WD_LAST);

  always_comb begin
    wd_d = wd_q;
    if (enter_wait || accept) begin
      wd_d = '0;
    end else if (stall) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Everything except grant is combinational and forced quiet while reset is held.
  assign fire        = accept && !rst;
  assign r_ready     = fire ? owner_oh : 2'b00;
  assign op_valid_in = fire;
  assign op_in       = fire ? r_op[owner_q] : 4'h0;
  assign done        = (finish && !rst) ? owner_oh : 2'b00;
  assign error       = timeout_hit && !rst;
  assign grant       = grant_q;

endmodule

// File: doc/lowres_op_arbiter.md
LOWRES_OP_ARBITER -- requirements
Module: lowres_op_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1048576, watchdog limit in cycles; used only when LOWRES_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  2  per-requester job request, level; bit i = requester i.
REQ-005 r_op  input  2x4  per-requester opcode to the core (same encoding as the core op port).
REQ-006 r_valid  input  2  per-requester opcode valid.
REQ-007 r_last  input  2  marks the final opcode of the requester's job; qualified by r_valid.
REQ-008 r_ready  output  2  opcode accepted this cycle; one-hot or zero.
REQ-009 grant  output  2  registered ownership of the core; one-hot or zero.
REQ-010 done  output  2  one-cycle pulse: owner's job complete.
REQ-011 error  output  1  one-cycle watchdog abort pulse (0 when macro absent).
REQ-012 op_in  output  4  opcode to core.
REQ-013 op_valid_in  output  1  opcode strobe to core.
REQ-014 ready_out  input  1  core idle/ready for next opcode.

Function
REQ-015 States: IDLE, ISSUE, BLANK, DRAIN; encoding is free.
REQ-016 IDLE: grant=0; if any req bit set, register grant to the winner and go ISSUE next cycle (grant latency 1 cycle from req).
REQ-017 Arbitration: single request wins; if both set, the requester indicated by priority pointer prio wins.
REQ-018 prio resets to 0; on each job completion or abort, prio becomes the index not just served.
REQ-019 ISSUE: when r_valid[owner] && ready_out, same cycle (combinational): r_ready[owner]=1, op_in=r_op[owner], op_valid_in=1.
REQ-020 Accepted opcode without r_last -> BLANK; with r_last -> DRAIN via one BLANK cycle.
REQ-021 Outside an accepting cycle: op_in=0, op_valid_in=0, r_ready=0.
REQ-022 BLANK: lasts exactly one cycle, ready_out ignored; then ISSUE (non-last) or DRAIN (last).
REQ-023 DRAIN: when ready_out=1, pulse done[owner] same cycle, clear grant, update prio, go IDLE.
REQ-024 Non-owner r_valid is ignored; its r_ready stays 0.
REQ-025 Owner deasserting req mid-job has no effect; the job ends only via r_last+DRAIN or watchdog.
REQ-026 done cycle and new req in the same cycle: arbitration occurs from IDLE next cycle; at least one grant=0 cycle between jobs.
REQ-027 Never more than one op_valid_in pulse per accepted opcode; never two op_valid_in in consecutive cycles.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, grant=0, prio=0, watchdog count=0.
REQ-029 During and after reset until the next grant: r_ready=0, done=0, error=0, op_in=0, op_valid_in=0.
REQ-030 Reset mid-job abandons the job silently: no done, no error.

Configuration
REQ-031 Macro LOWRES_ARB_TIMEOUT_EN defined: a counter, cleared on entering ISSUE or DRAIN and on each accepted opcode, increments each cycle in ISSUE or DRAIN with ready_out=0.
REQ-032 When the counter reaches TIMEOUT_CYCLES: pulse error, clear grant, update prio, go IDLE, no done pulse.
REQ-033 Macro undefined: no counter is instantiated, error is tied to 0, and the arbiter waits indefinitely.

Verification
REQ-034 req=01, ops 0xF,0x7(last), ready_out=1 throughout -> grant=01 one cycle after req; op_valid_in with op_in=0xF then 0x7 separated by the BLANK cycle; done=01 in the first DRAIN cycle.
REQ-035 req=11 from reset -> requester 0 served first; after its done, requester 1 granted after one idle cycle; next simultaneous req=11 serves requester 0.
REQ-036 Owner r_valid=1 with ready_out=0 for 5 cycles -> r_ready=0 and op_valid_in=0 for those 5 cycles; opcode issued in the cycle ready_out rises.
REQ-037 Non-owner r_valid=1, r_op=0x4 during another's job -> r_ready stays 0; op_in never equals 0x4 during that job.
REQ-038 rst pulse while in DRAIN -> next cycle grant=0, done=0, prio=0.
REQ-039 Macro on, TIMEOUT_CYCLES=16, ready_out held 0 in DRAIN -> error pulse after 16 cycles, grant=0, done never pulsed; macro off -> grant held indefinitely.
